// File: rtl/key_pkg.sv
// key_pkg: shared types and board defaults for the pushbutton event decoder.
// The default cycle constants assume the 50 MHz board clock.
package key_pkg;

    // Per-key debounce / hold state machine encoding.
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        DB_PRESS   = 3'd1,
        PRESSED    = 3'd2,
        HELD       = 3'd3,
        DB_RELEASE = 3'd4
    } key_state_t;

    localparam int unsigned DEF_N_KEYS       = 3;
    localparam int unsigned DEF_DEBOUNCE_CYC = 500_000;     // 10 ms
    localparam int unsigned DEF_HOLD_CYC     = 50_000_000;  // 1 s
    localparam int unsigned DEF_REPEAT_CYC   = 12_500_000;  // 250 ms

    // Largest of three cycle constants; sizes the shared counter width.
    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return m;
    endfunction

endpackage

// File: rtl/key_channel.sv
// key_channel: one pushbutton's synchronizer, debounce/hold FSM, counters and
// event strobes. The raw key is active-low and asynchronous to clk.
// Optional auto-repeat while HELD is compiled in with `define KEY_REPEAT_EN;
// without it repeat_pulse is tied low and no repeat counter exists.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   IDLE       | key released and stable; waiting for a synchronized press
//   DB_PRESS   | press seen, counting stable cycles before accepting it
//   PRESSED    | press accepted; counting towards the long-hold threshold
//   HELD       | long hold reached; held=1 (auto-repeat runs here if built)
//   DB_RELEASE | release seen, counting stable cycles; was_held picks return
module key_channel
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int unsigned HOLD_CYC     = DEF_HOLD_CYC,
    parameter int unsigned REPEAT_CYC   = DEF_REPEAT_CYC
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic key_down,
    output logic press_pulse,
    output logic release_pulse,
    output logic hold_pulse,
    output logic held,
    output logic repeat_pulse
);

    // One counter width covers every terminal count so no counter can wrap.
    localparam int unsigned CNT_W = $clog2(max3(DEBOUNCE_CYC, HOLD_CYC, REPEAT_CYC) + 1);

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic p_s;

    key_state_t       state_q, state_d;
    logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             was_held_q, was_held_d;

    logic key_down_q, key_down_d;
    logic held_q, held_d;
    logic press_q, press_d;
    logic release_q, release_d;
    logic hold_q, hold_d;

    // Two-flop synchronizer; nothing looks at the raw pin before the second flop.
    always_comb begin
        sync1_d = key_n;
        sync2_d = sync1_q;
    end

    assign p_s = ~sync2_q;

    // Next-state and strobe decode for the debounce / hold state machine.
    always_comb begin
        state_d    = state_q;
        db_cnt_d   = db_cnt_q;
        hold_cnt_d = hold_cnt_q;
        was_held_d = was_held_q;
        key_down_d = key_down_q;
        held_d     = held_q;
        press_d    = 1'b0;
        release_d  = 1'b0;
        hold_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                db_cnt_d   = '0;
                hold_cnt_d = '0;
                if (p_s) begin
                    state_d = DB_PRESS;
                end
            end

            DB_PRESS: begin
                if (!p_s) begin
                    state_d = IDLE;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d    = PRESSED;
                    press_d    = 1'b1;
                    key_down_d = 1'b1;
                    db_cnt_d   = '0;
                    hold_cnt_d = '0;
                end else begin
                    db_cnt_d = sat_inc(db_cnt_q);
                end
            end

            // Reaching the hold threshold wins over a release seen the same
            // cycle; the release is then taken from HELD one cycle later.
            PRESSED: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d = HELD;
                    hold_d  = 1'b1;
                    held_d  = 1'b1;
                end else if (!p_s) begin
                    state_d    = DB_RELEASE;
                    was_held_d = 1'b0;
                    db_cnt_d   = '0;
                end else begin
                    hold_cnt_d = sat_inc(hold_cnt_q);
                end
            end

            HELD: begin
                if (!p_s) begin
                    state_d    = DB_RELEASE;
                    was_held_d = 1'b1;
                    db_cnt_d   = '0;
                end
            end

            // A release that does not survive debounce returns to where it came
            // from; the hold count was frozen here, so PRESSED simply resumes.
            DB_RELEASE: begin
                if (p_s) begin
                    state_d = was_held_q ? HELD : PRESSED;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d    = IDLE;
                    release_d  = 1'b1;
                    key_down_d = 1'b0;
                    held_d     = 1'b0;
                    db_cnt_d   = '0;
                end else begin
                    db_cnt_d = sat_inc(db_cnt_q);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters, synchronizer and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            state_q    <= IDLE;
            db_cnt_q   <= '0;
            hold_cnt_q <= '0;
            was_held_q <= 1'b0;
            key_down_q <= 1'b0;
            held_q     <= 1'b0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            hold_q     <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            state_q    <= state_d;
            db_cnt_q   <= db_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            was_held_q <= was_held_d;
            key_down_q <= key_down_d;
            held_q     <= held_d;
            press_q    <= press_d;
            release_q  <= release_d;
            hold_q     <= hold_d;
        end
    end

    assign key_down      = key_down_q;
    assign held          = held_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign hold_pulse    = hold_q;

`ifdef KEY_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYC - 1);

    logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             repeat_q, repeat_d;

    // Auto-repeat: counts only while HELD with the key still down, freezes in
    // DB_RELEASE so a glitch does not restart the period, clears elsewhere.
    always_comb begin
        rep_cnt_d = rep_cnt_q;
        repeat_d  = 1'b0;
        if ((state_q == HELD) && p_s) begin
            if (rep_cnt_q == REP_LAST) begin
                repeat_d  = 1'b1;
                rep_cnt_d = '0;
            end else begin
                rep_cnt_d = sat_inc(rep_cnt_q);
            end
        end else if (state_q != DB_RELEASE) begin
            rep_cnt_d = '0;
        end
    end

    // Repeat counter and strobe registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            rep_cnt_q <= '0;
            repeat_q  <= 1'b0;
        end else begin
            rep_cnt_q <= rep_cnt_d;
            repeat_q  <= repeat_d;
        end
    end

    assign repeat_pulse = repeat_q;
`else
    assign repeat_pulse = 1'b0;
`endif

endmodule

// File: rtl/key_event_decoder.sv
// key_event_decoder: turns N_KEYS raw active-low pushbuttons into debounced
// levels and press / release / long-hold strobes for the puzzle logic.
// Each key is handled by its own key_channel; keys never interact.
// Define KEY_REPEAT_EN to get auto-repeat strobes while a key is HELD;
// otherwise repeat_pulse is constant 0 (ports are the same in both builds).
module key_event_decoder
    import key_pkg::*;
#(
    parameter int unsigned N_KEYS       = DEF_N_KEYS,
    parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int unsigned HOLD_CYC     = DEF_HOLD_CYC,
    parameter int unsigned REPEAT_CYC   = DEF_REPEAT_CYC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_KEYS-1:0] KEY,
    output logic [N_KEYS-1:0] key_down,
    output logic [N_KEYS-1:0] press_pulse,
    output logic [N_KEYS-1:0] release_pulse,
    output logic [N_KEYS-1:0] hold_pulse,
    output logic [N_KEYS-1:0] held,
    output logic [N_KEYS-1:0] repeat_pulse
);

    for (genvar i = 0; i < N_KEYS; i++) begin : g_key
        key_channel #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC),
            .HOLD_CYC     (HOLD_CYC),
            .REPEAT_CYC   (REPEAT_CYC)
        ) u_channel (
            .clk           (clk),
            .reset         (reset),
            .key_n         (KEY[i]),
            .key_down      (key_down[i]),
            .press_pulse   (press_pulse[i]),
            .release_pulse (release_pulse[i]),
            .hold_pulse    (hold_pulse[i]),
            .held          (held[i]),
            .repeat_pulse  (repeat_pulse[i])
        );
    end

endmodule
